// File: rtl/serial_adder_pkg.sv
// serial_adder shared types and constants.
// Imported by the serial adder top and its handshake interface users.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 64;

  // Bit counter must hold WIDTH-1 but never collapse to zero bits.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done operand and result bundle for serial_adder.
// master drives operands, slave returns registered results.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c;

  modport master (
    output start,
    output a,
    output b,
    output cin,
    input  busy,
    input  done,
    input  s,
    input  c
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  cin,
    output busy,
    output done,
    output s,
    output c
  );

endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half-adder stages.
// Shared by serial and ripple adder blocks.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  assign s1 = a ^ b;
  assign c1 = a & b;

  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;

  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Results register on the completion edge and hold until the next one.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_s;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_next;
  logic             last;
  logic             accept;

  full_adder_cell u_fa (
    .a  (sh_a[0]),
    .b  (sh_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so the word is aligned after WIDTH shifts.
  always_comb begin
    sum_next = sh_s >> 1;
    sum_next[WIDTH-1] = fa_s;
  end

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = bus.start &&
                  ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      sh_s   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      s_q    <= '0;
      c_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            sh_a   <= bus.a;
            sh_b   <= bus.b;
            sh_s   <= '0;
            carry  <= bus.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          sh_s  <= sum_next;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (last) begin
            s_q    <= sum_next;
            c_q    <= fa_co;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.c    = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Expected results come from plain integer addition.
module tb_serial_adder;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cyc;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic op8(input  logic [7:0] a,
                     input  logic [7:0] b,
                     input  logic       ci,
                     output logic [7:0] rs,
                     output logic       rc,
                     output int         lat);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = ci;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.cin   = 1'($urandom);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus8.done) begin
        lat = n;
        break;
      end
    end
    rs = bus8.s;
    rc = bus8.c;
  endtask

  task automatic op1(input  logic a,
                     input  logic b,
                     input  logic ci,
                     output logic rs,
                     output logic rc,
                     output int   lat);
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.a     = a;
    bus1.b     = b;
    bus1.cin   = ci;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (bus1.done) begin
        lat = n;
        break;
      end
    end
    rs = bus1.s;
    rc = bus1.c;
  endtask

  initial begin
    logic [7:0] rs;
    logic       rc;
    logic       rs1;
    logic       rc1;
    int         lat;
    int         t1;
    int         t2;
    int         bad;
    int         dcnt;
    logic [8:0] exp9;
    logic [1:0] exp2;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rci;

    errors = 0;
    checks = 0;
    vecs[0] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

    rst = 1'b1;
    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus8.cin = 1'b0;
    bus1.start = 1'b0;
    bus1.a = '0;
    bus1.b = '0;
    bus1.cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("idle_outputs",
          {bus8.busy, bus8.done, bus8.c, bus8.s},
          64'h0);
    end

    for (int i = 0; i < 3; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].ci, rs, rc, lat);
      chk("vec_lat", lat, 8);
      chk("vec_s", rs, vecs[i].s);
      chk("vec_c", rc, vecs[i].c);
      chk("vec_busy_at_done", bus8.busy, 0);
    end

    for (int i = 0; i < 25; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rci = 1'($urandom);
      exp9 = 9'(ra) + 9'(rb) + 9'(rci);
      op8(ra, rb, rci, rs, rc, lat);
      chk("rand_lat", lat, 8);
      chk("rand_sum", {rc, rs}, exp9);
    end

    // Back-to-back with start held high through the DONE cycle.
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = 8'h01;
    bus8.b = 8'h01;
    bus8.cin = 1'b0;
    @(posedge clk);
    #1;
    bus8.a = 8'h10;
    bus8.b = 8'h20;
    t1 = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus8.done) begin
        t1 = cyc;
        break;
      end
    end
    chk("b2b_first_seen", t1 >= 0, 1);
    chk("b2b_first_s", bus8.s, 8'h02);
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    chk("b2b_reaccepted_busy", bus8.busy, 1);
    t2 = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus8.done) begin
        t2 = cyc;
        break;
      end
    end
    chk("b2b_spacing", t2 - t1, 9);
    chk("b2b_second_s", bus8.s, 8'h30);

    // Start during RUN must be ignored.
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = 8'h11;
    bus8.b = 8'h22;
    bus8.cin = 1'b0;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bad = 0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) begin
        bus8.start = 1'b1;
        bus8.a = 8'hF0;
        bus8.b = 8'h0F;
        bus8.cin = 1'b1;
      end else begin
        bus8.start = 1'b0;
      end
      if (bus8.done) begin
        lat = n;
        break;
      end
      if (bus8.s !== 8'h30) bad++;
    end
    chk("ign_s_held", bad, 0);
    chk("ign_lat", lat, 8);
    chk("ign_result", {bus8.c, bus8.s}, 9'h033);
    @(posedge clk);
    #1;
    chk("ign_not_queued", {bus8.busy, bus8.done}, 0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = 8'h55;
    bus8.b = 8'h66;
    bus8.cin = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", bus8.busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_outputs",
        {bus8.busy, bus8.done, bus8.c, bus8.s},
        64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (bus8.done || bus8.busy) dcnt++;
    end
    chk("rst_no_done", dcnt, 0);
    op8(8'h07, 8'h09, 1'b0, rs, rc, lat);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_sum", {rc, rs}, 9'h010);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      exp2 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      op1(v[2], v[1], v[0], rs1, rc1, lat);
      chk("w1_lat", lat, 1);
      chk("w1_sum", {rc1, rs1}, exp2);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
